pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter REG_AW, default 5, register-address width.
REQ-002 Parameter MUL_CYCLES, default 3, total EX occupancy of a multiply (>=1).
REQ-003 Parameter DIV_CYCLES, default 33, total EX occupancy of a divide (>=1, <=255).
REQ-004 Port clk  in  1  clock; all state SHALL update on the rising edge.
REQ-005 Port rst_n  in  1  reset, synchronous, active-low.
REQ-006 Port id_rs1, id_rs2  in  REG_AW each  source registers of the instruction in ID.
REQ-007 Port id_use_rs1, id_use_rs2  in  1 each  the ID instruction reads that source.
REQ-008 Port ex_valid  in  1  EX holds a real instruction.
REQ-009 Port ex_rd  in  REG_AW  EX destination register.
REQ-010 Port ex_is_load  in  1  EX instruction is a load.
REQ-011 Port ex_is_mul, ex_is_div  in  1 each  EX instruction is multi-cycle.
REQ-012 Port ex_redirect  in  1  EX resolved a taken branch/jump (pcmux_sel != next-PC).
REQ-013 Port mem_busy  in  1  MEM stage cannot accept this cycle.
REQ-014 Port stall_if, stall_id, stall_ex  out  1 each  hold that stage's pipeline register.
REQ-015 Port flush_id, flush_ex  out  1 each  load a bubble (all-zero cword) into that stage's register.
REQ-016 Port md_busy  out  1  multi-cycle operation in progress.
REQ-017 Port state  out  2  current FSM state (RUN=0, MDIV=1, MEMW=2, REDIR=3).

Function
REQ-018 FSM states SHALL be RUN, MDIV, MEMW, REDIR with a REQ-017 encoding.
REQ-019 Condition priority within a cycle SHALL be: mem_busy > multi-cycle > load-use > redirect.
REQ-020 mem_busy=1 (any state) SHALL assert stall_if, stall_id, stall_ex combinationally and deassert both flushes; FSM enters/stays MEMW, saving the interrupted state.
REQ-021 mem_busy falling SHALL return the FSM next cycle to the saved state with the multi-cycle counter unchanged (counter frozen during MEMW).
REQ-022 In RUN, ex_valid & (ex_is_mul|ex_is_div) & ~mem_busy SHALL load counter with (MUL_CYCLES or DIV_CYCLES)-1 and enter MDIV; if that value is 0 no MDIV entry occurs.
REQ-023 In MDIV, counter SHALL decrement by 1 per cycle; stall_if/id/ex=1, flush_ex=0, md_busy=1; exit to RUN when counter reaches 0, that cycle being the last stalled cycle.
REQ-024 A multiply therefore SHALL occupy EX exactly MUL_CYCLES cycles, a divide exactly DIV_CYCLES cycles (excluding MEMW cycles).
REQ-025 Load-use hazard: ex_valid & ex_is_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)) SHALL assert stall_if, stall_id and flush_ex for exactly one cycle, stall_ex=0.
REQ-026 Register x0 SHALL never cause a hazard.
REQ-027 Redirect: ex_valid & ex_redirect in RUN with no higher-priority condition SHALL assert flush_id and flush_ex that cycle and enter REDIR.
REQ-028 REDIR SHALL last one cycle asserting flush_id only (kills the wrong-path fetch in flight) then return to RUN; a load-use detection in REDIR SHALL be ignored.
REQ-029 Redirect on an instruction that is multi-cycle SHALL be honoured on the MDIV exit cycle, not on entry.
REQ-030 Outputs SHALL be combinational from state and inputs; all state (FSM, counter, saved state) registered.
REQ-031 With no hazard in RUN all five control outputs SHALL be 0.

Reset
REQ-032 rst_n=0 at a clock edge SHALL set state=RUN, counter=0, saved state=RUN, md_busy=0, abandoning any MDIV/MEMW/REDIR in progress.
REQ-033 While rst_n=0 all stall and flush outputs SHALL be 0.

Verification
REQ-034 Load x5 in EX, ID uses rs2=x5 -> one cycle stall_if=stall_id=flush_ex=1, stall_ex=0; next cycle all 0.
REQ-035 Divide in EX, DIV_CYCLES=33, mem_busy=0 -> md_busy and stall_ex high 32 cycles, then state RUN; same with rs1=x0 load hazard -> no stall.
REQ-036 Divide starts, mem_busy=1 for 4 cycles at count 10 -> state MEMW 4 cycles, resumes MDIV at 10, total EX occupancy 37 cycles.
REQ-037 Taken branch in EX -> cycle N flush_id=flush_ex=1, cycle N+1 state REDIR with flush_id=1 only, cycle N+2 RUN.
REQ-038 Load-use and redirect same cycle -> load-use response only; rst_n=0 mid-MDIV -> next cycle state=0, md_busy=0, all outputs 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard controller for memory waits, multi-cycle EX ops, load-use and redirect
module pipe_ctrl #(
   parameter int REG_AW     = 5,
   parameter int MUL_CYCLES = 3,
   parameter int DIV_CYCLES = 33
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic              ex_valid,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_is_load,
   input  logic              ex_is_mul,
   input  logic              ex_is_div,
   input  logic              ex_redirect,
   input  logic              mem_busy,
   output logic              stall_if,
   output logic              stall_id,
   output logic              stall_ex,
   output logic              flush_id,
   output logic              flush_ex,
   output logic              md_busy,
   output logic [1:0]        state
);
   typedef enum logic [1:0] {RUN = 2'd0, MDIV = 2'd1, MEMW = 2'd2, REDIR = 2'd3} state_t;
   localparam logic [7:0] MUL_LD = 8'(MUL_CYCLES - 1);
   localparam logic [7:0] DIV_LD = 8'(DIV_CYCLES - 1);
   state_t     cur, nxt, sav, sav_n;
   logic [7:0] cnt, cnt_n, md_ld;
   logic       md_go, load_use, redir, last;
   // The entry cycle counts as the first EX cycle, so MDIV runs for the remaining
   // count and its final cycle (count 1) releases the instruction out of EX.
   assign md_ld    = ex_is_div ? DIV_LD : MUL_LD;
   assign md_go    = ex_valid & (ex_is_mul | ex_is_div) & (md_ld != 8'd0);
   assign load_use = ex_valid & ex_is_load & (|ex_rd) &
                     ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
   assign redir    = ex_valid & ex_redirect;
   assign last     = cnt < 8'd2;
   assign state    = cur;
   assign md_busy  = (cur == MDIV) | ((cur == MEMW) & (sav == MDIV));
   // State, saved state and multi-cycle counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur <= RUN;
         sav <= RUN;
         cnt <= 8'd0;
      end else begin
         cur <= nxt;
         sav <= sav_n;
         cnt <= cnt_n;
      end
   end
   // Next state and stall/flush decode, prioritised mem_busy > multi-cycle > load-use > redirect
   always_comb begin
      nxt      = cur;
      sav_n    = sav;
      cnt_n    = cnt;
      stall_if = 1'b0;
      stall_id = 1'b0;
      stall_ex = 1'b0;
      flush_id = 1'b0;
      flush_ex = 1'b0;
      if (rst_n) begin
         if (mem_busy) begin
            {stall_if, stall_id, stall_ex} = 3'b111;
            nxt   = MEMW;
            sav_n = (cur == MEMW) ? sav : cur;
            cnt_n = (cur == MDIV && !last) ? cnt - 8'd1 : cnt;
         end else begin
            case (cur)
               RUN: begin
                  if (md_go) begin
                     {stall_if, stall_id, stall_ex} = 3'b111;
                     cnt_n = md_ld;
                     nxt   = MDIV;
                  end else if (load_use) begin
                     {stall_if, stall_id, flush_ex} = 3'b111;
                  end else if (redir) begin
                     {flush_id, flush_ex} = 2'b11;
                     nxt = REDIR;
                  end
               end
               MDIV: begin
                  {stall_if, stall_id, stall_ex} = {3{!last}};
                  {flush_id, flush_ex} = {2{last & redir}};
                  cnt_n = last ? 8'd0 : cnt - 8'd1;
                  nxt   = !last ? MDIV : (redir ? REDIR : RUN);
               end
               MEMW: begin
                  {stall_if, stall_id, stall_ex} = 3'b111;
                  nxt = sav;
               end
               REDIR: begin
                  flush_id = 1'b1;
                  nxt      = RUN;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenario checks of pipe_ctrl with default parameters
module tb_pipe_ctrl;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_use_rs1, id_use_rs2, ex_valid, ex_is_load, ex_is_mul, ex_is_div, ex_redirect, mem_busy;
   logic       stall_if, stall_id, stall_ex, flush_id, flush_ex, md_busy;
   logic [1:0] state;
   logic [7:0] obs;
   int         checks = 0;
   int         fails = 0;

   // {stall_if, stall_id, stall_ex, flush_id, flush_ex, md_busy, state}
   localparam logic [7:0] O_IDLE    = 8'b000_00_0_00;
   localparam logic [7:0] O_LU      = 8'b110_01_0_00;
   localparam logic [7:0] O_STALL   = 8'b111_00_0_00;
   localparam logic [7:0] O_MDIV    = 8'b111_00_1_01;
   localparam logic [7:0] O_MDLAST  = 8'b000_00_1_01;
   localparam logic [7:0] O_MDREDIR = 8'b000_11_1_01;
   localparam logic [7:0] O_MEMW_MD = 8'b111_00_1_10;
   localparam logic [7:0] O_MEMW    = 8'b111_00_0_10;
   localparam logic [7:0] O_BRANCH  = 8'b000_11_0_00;
   localparam logic [7:0] O_REDIR   = 8'b000_10_0_11;

   pipe_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_is_mul(ex_is_mul),
      .ex_is_div(ex_is_div), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
      .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
      .flush_id(flush_id), .flush_ex(flush_ex), .md_busy(md_busy), .state(state)
   );

   assign obs = {stall_if, stall_id, stall_ex, flush_id, flush_ex, md_busy, state};

   always #5 clk = ~clk;

   task automatic clear();
      id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
      ex_valid = 0; ex_rd = 0; ex_is_load = 0; ex_is_mul = 0; ex_is_div = 0;
      ex_redirect = 0; mem_busy = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 0;
      clear();
      mem_busy = 1; ex_valid = 1; ex_redirect = 1; ex_is_load = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1;
      tick();
      tick();
      @(negedge clk);
      checks++;
      if (obs !== O_IDLE) begin fails++; $display("FAIL reset_hold: got %b expected %b", obs, O_IDLE); end
      tick();
      clear();
      rst_n = 1;
      @(negedge clk);
      checks++;
      if (obs !== O_IDLE) begin fails++; $display("FAIL reset_idle: got %b expected %b", obs, O_IDLE); end
      tick();
   endtask

   task automatic test_load_use();
      clear(); ex_valid = 1; ex_is_load = 1; ex_rd = 5; id_use_rs2 = 1; id_rs2 = 5;
      @(negedge clk);
      checks++;
      if (obs !== O_LU) begin fails++; $display("FAIL lu_rs2: got %b expected %b", obs, O_LU); end
      tick();
      clear(); id_use_rs2 = 1; id_rs2 = 5;
      @(negedge clk);
      checks++;
      if (obs !== O_IDLE) begin fails++; $display("FAIL lu_after: got %b expected %b", obs, O_IDLE); end
      tick();
      clear(); ex_valid = 1; ex_is_load = 1; ex_rd = 9; id_use_rs1 = 1; id_rs1 = 9; id_rs2 = 4;
      @(negedge clk);
      checks++;
      if (obs !== O_LU) begin fails++; $display("FAIL lu_rs1: got %b expected %b", obs, O_LU); end
      tick();
      clear(); ex_valid = 1; ex_is_load = 1; ex_rd = 9; id_rs1 = 9;
      @(negedge clk);
      checks++;
      if (obs !== O_IDLE) begin fails++; $display("FAIL lu_unused: got %b expected %b", obs, O_IDLE); end
      tick();
      clear(); ex_valid = 1; ex_is_load = 0; ex_rd = 9; id_use_rs1 = 1; id_rs1 = 9;
      @(negedge clk);
      checks++;
      if (obs !== O_IDLE) begin fails++; $display("FAIL lu_not_load: got %b expected %b", obs, O_IDLE); end
      tick();
      clear(); ex_valid = 0; ex_is_load = 1; ex_rd = 9; id_use_rs1 = 1; id_rs1 = 9;
      @(negedge clk);
      checks++;
      if (obs !== O_IDLE) begin fails++; $display("FAIL lu_invalid: got %b expected %b", obs, O_IDLE); end
      tick();
      clear(); ex_valid = 1; ex_is_load = 1; ex_rd = 0; id_use_rs1 = 1; id_rs1 = 0; id_use_rs2 = 1; id_rs2 = 0;
      @(negedge clk);
      checks++;
      if (obs !== O_IDLE) begin fails++; $display("FAIL lu_x0: got %b expected %b", obs, O_IDLE); end
      tick();
      clear(); ex_valid = 1; ex_is_load = 1; ex_rd = 5; id_use_rs1 = 1; id_rs1 = 6; id_use_rs2 = 1; id_rs2 = 4;
      @(negedge clk);
      checks++;
      if (obs !== O_IDLE) begin fails++; $display("FAIL lu_nomatch: got %b expected %b", obs, O_IDLE); end
      tick();
   endtask

   task automatic test_div();
      int sx = 0;
      int mb = 0;
      logic [7:0] exp;
      clear(); ex_valid = 1; ex_is_div = 1; ex_redirect = 0;
      @(negedge clk);
      checks++;
      if (obs !== O_STALL) begin fails++; $display("FAIL div_entry: got %b expected %b", obs, O_STALL); end
      sx += stall_ex; mb += md_busy;
      for (int k = 1; k <= 32; k++) begin
         tick();
         @(negedge clk);
         exp = (k == 32) ? O_MDLAST : O_MDIV;
         checks++;
         if (obs !== exp) begin fails++; $display("FAIL div_cycle %0d: got %b expected %b", k, obs, exp); end
         sx += stall_ex; mb += md_busy;
      end
      checks++;
      if (sx != 32) begin fails++; $display("FAIL div_stall_ex_count: got %0d expected 32", sx); end
      checks++;
      if (mb != 32) begin fails++; $display("FAIL div_md_busy_count: got %0d expected 32", mb); end
      tick();
      clear();
      @(negedge clk);
      checks++;
      if (obs !== O_IDLE) begin fails++; $display("FAIL div_done: got %b expected %b", obs, O_IDLE); end
      tick();
   endtask

   task automatic test_div_memw();
      int occ = 1;
      int mw = 0;
      logic [7:0] exp;
      clear(); ex_valid = 1; ex_is_div = 1;
      @(negedge clk);
      for (int k = 1; k <= 36; k++) begin
         tick();
         mem_busy = (k >= 22 && k <= 25);
         @(negedge clk);
         exp = (k >= 23 && k <= 26) ? O_MEMW_MD : ((k == 36) ? O_MDLAST : O_MDIV);
         checks++;
         if (obs !== exp) begin fails++; $display("FAIL divmw_cycle %0d: got %b expected %b", k, obs, exp); end
         occ++;
         mw += (state == 2'd2);
      end
      checks++;
      if (mw != 4) begin fails++; $display("FAIL divmw_memw_count: got %0d expected 4", mw); end
      tick();
      clear();
      @(negedge clk);
      checks++;
      if (obs !== O_IDLE) begin fails++; $display("FAIL divmw_done: got %b expected %b (occupancy %0d of 37)", obs, O_IDLE, occ); end
      tick();
   endtask

   task automatic test_mul_redirect();
      clear(); ex_valid = 1; ex_is_mul = 1; ex_redirect = 1;
      @(negedge clk);
      checks++;
      if (obs !== O_STALL) begin fails++; $display("FAIL mul_entry: got %b expected %b", obs, O_STALL); end
      tick();
      @(negedge clk);
      checks++;
      if (obs !== O_MDIV) begin fails++; $display("FAIL mul_mdiv: got %b expected %b", obs, O_MDIV); end
      tick();
      @(negedge clk);
      checks++;
      if (obs !== O_MDREDIR) begin fails++; $display("FAIL mul_exit_redirect: got %b expected %b", obs, O_MDREDIR); end
      tick();
      clear();
      @(negedge clk);
      checks++;
      if (obs !== O_REDIR) begin fails++; $display("FAIL mul_redir_state: got %b expected %b", obs, O_REDIR); end
      tick();
      @(negedge clk);
      checks++;
      if (obs !== O_IDLE) begin fails++; $display("FAIL mul_back_run: got %b expected %b", obs, O_IDLE); end
      tick();
   endtask

   task automatic test_redirect();
      clear(); ex_valid = 1; ex_redirect = 1;
      @(negedge clk);
      checks++;
      if (obs !== O_BRANCH) begin fails++; $display("FAIL br_n: got %b expected %b", obs, O_BRANCH); end
      tick();
      clear(); ex_valid = 1; ex_is_load = 1; ex_rd = 8; id_use_rs1 = 1; id_rs1 = 8;
      @(negedge clk);
      checks++;
      if (obs !== O_REDIR) begin fails++; $display("FAIL br_n1: got %b expected %b", obs, O_REDIR); end
      tick();
      clear();
      @(negedge clk);
      checks++;
      if (obs !== O_IDLE) begin fails++; $display("FAIL br_n2: got %b expected %b", obs, O_IDLE); end
      tick();
   endtask

   task automatic test_lu_vs_redirect();
      clear(); ex_valid = 1; ex_is_load = 1; ex_rd = 7; id_use_rs1 = 1; id_rs1 = 7; ex_redirect = 1;
      @(negedge clk);
      checks++;
      if (obs !== O_LU) begin fails++; $display("FAIL luredir_same: got %b expected %b", obs, O_LU); end
      tick();
      clear();
      @(negedge clk);
      checks++;
      if (obs !== O_IDLE) begin fails++; $display("FAIL luredir_next: got %b expected %b", obs, O_IDLE); end
      tick();
   endtask

   task automatic test_memw_run();
      clear(); ex_valid = 1; ex_redirect = 1; mem_busy = 1;
      @(negedge clk);
      checks++;
      if (obs !== O_STALL) begin fails++; $display("FAIL mw_first: got %b expected %b", obs, O_STALL); end
      tick();
      @(negedge clk);
      checks++;
      if (obs !== O_MEMW) begin fails++; $display("FAIL mw_hold: got %b expected %b", obs, O_MEMW); end
      tick();
      mem_busy = 0;
      @(negedge clk);
      checks++;
      if (obs !== O_MEMW) begin fails++; $display("FAIL mw_fall: got %b expected %b", obs, O_MEMW); end
      tick();
      @(negedge clk);
      checks++;
      if (obs !== O_BRANCH) begin fails++; $display("FAIL mw_resume_branch: got %b expected %b", obs, O_BRANCH); end
      tick();
      clear();
      @(negedge clk);
      checks++;
      if (obs !== O_REDIR) begin fails++; $display("FAIL mw_redir: got %b expected %b", obs, O_REDIR); end
      tick();
   endtask

   task automatic test_reset_mid_mdiv();
      clear(); ex_valid = 1; ex_is_div = 1;
      for (int k = 0; k < 6; k++) tick();
      @(negedge clk);
      checks++;
      if (obs !== O_MDIV) begin fails++; $display("FAIL rstmd_before: got %b expected %b", obs, O_MDIV); end
      tick();
      rst_n = 0;
      @(negedge clk);
      checks++;
      if (obs !== O_MDLAST) begin fails++; $display("FAIL rstmd_gated: got %b expected %b", obs, O_MDLAST); end
      tick();
      @(negedge clk);
      checks++;
      if (obs !== O_IDLE) begin fails++; $display("FAIL rstmd_after: got %b expected %b", obs, O_IDLE); end
      tick();
      rst_n = 1;
      clear();
      @(negedge clk);
      checks++;
      if (obs !== O_IDLE) begin fails++; $display("FAIL rstmd_release: got %b expected %b", obs, O_IDLE); end
      tick();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_div();
      test_div_memw();
      test_mul_redirect();
      test_redirect();
      test_lu_vs_redirect();
      test_memw_run();
      test_reset_mid_mdiv();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
